// File: rtl/spi_flash_init_seq.sv
// SPI NOR flash power-up sequencer: soft reset (0x66/0x99), settle wait, optional
// quad-enable status write, then RDSR polling until WIP clears. Drives a byte-level
// SPI engine through a valid/ready command channel and an rx_valid completion pulse.
module spi_flash_init_seq #(
  parameter int unsigned RST_WAIT_CYCLES = 1000,
  parameter bit          ENABLE_QE       = 1'b1,
  parameter int unsigned MAX_POLLS       = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_byte,
  output logic       cmd_last,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       init_done,
  output logic       init_err,
  output logic       busy
);

  typedef enum logic [3:0] {
    StRsten, StRst, StRwait, StWren, StWrsr0, StWrsr1, StPollCmd, StPollRd, StDone, StErr
  } state_e;

  typedef enum logic {PhIssue, PhWaitRx} phase_e;

  localparam int unsigned WaitW = (RST_WAIT_CYCLES > 1) ? $clog2(RST_WAIT_CYCLES) : 1;
  localparam logic [WaitW-1:0] WaitLast =
      WaitW'((RST_WAIT_CYCLES > 0) ? RST_WAIT_CYCLES - 1 : 0);
  localparam int unsigned PollW = (MAX_POLLS > 0) ? $clog2(MAX_POLLS + 1) : 1;
  localparam logic [PollW-1:0] PollLast = PollW'((MAX_POLLS > 0) ? MAX_POLLS - 1 : 0);

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [7:0]        cmd_byte_q, cmd_byte_d;
  logic              cmd_last_q, cmd_last_d;
  logic              issue_d;

  // Only the WIP bit of the status byte matters.
  logic unused_rx_bits;
  assign unused_rx_bits = ^rx_byte[7:1];

  function automatic logic [7:0] byte_of(state_e s);
    case (s)
      StRsten:   byte_of = 8'h66;
      StRst:     byte_of = 8'h99;
      StWren:    byte_of = 8'h06;
      StWrsr0:   byte_of = 8'h01;
      StWrsr1:   byte_of = 8'h40;
      StPollCmd: byte_of = 8'h05;
      default:   byte_of = 8'h00;
    endcase
  endfunction

  // cmd_last marks the final byte of each CS-framed command.
  function automatic logic last_of(state_e s);
    case (s)
      StWrsr0, StPollCmd: last_of = 1'b0;
      default:            last_of = 1'b1;
    endcase
  endfunction

  // Where to go once the settle wait is over (or skipped).
  function automatic state_e after_wait();
    after_wait = ENABLE_QE ? StWren : StDone;
  endfunction

  // Next-state logic plus the registered-output next values.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    wait_cnt_d = wait_cnt_q;
    poll_cnt_d = poll_cnt_q;

    unique case (state_q)
      StRwait: begin
        if (wait_cnt_q == WaitLast) begin
          state_d    = after_wait();
          phase_d    = PhIssue;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StDone, StErr: ;
      default: begin
        if (phase_q == PhIssue) begin
          // cmd_valid_q is low only in the first cycle after reset release.
          if (cmd_valid_q && cmd_ready) phase_d = PhWaitRx;
        end else if (rx_valid) begin
          phase_d = PhIssue;
          case (state_q)
            StRsten:   state_d = StRst;
            StRst:     state_d = (RST_WAIT_CYCLES == 0) ? after_wait() : StRwait;
            StWren:    state_d = StWrsr0;
            StWrsr0:   state_d = StWrsr1;
            StWrsr1:   state_d = StPollCmd;
            StPollCmd: state_d = StPollRd;
            StPollRd: begin
              if (!rx_byte[0]) begin
                state_d = StDone;
              end else if (poll_cnt_q == PollLast) begin
                state_d = StErr;
              end else begin
                poll_cnt_d = poll_cnt_q + 1'b1;
                state_d    = StPollCmd;
              end
            end
            default: state_d = state_q;
          endcase
        end
      end
    endcase

    issue_d     = (phase_d == PhIssue) &&
                  !(state_d inside {StRwait, StDone, StErr});
    cmd_valid_d = issue_d;
    cmd_byte_d  = issue_d ? byte_of(state_d) : 8'h00;
    cmd_last_d  = issue_d ? last_of(state_d) : 1'b0;
  end

  // State, counters and command outputs; reset aborts any byte or wait in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRsten;
      phase_q     <= PhIssue;
      wait_cnt_q  <= '0;
      poll_cnt_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'h00;
      cmd_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      wait_cnt_q  <= wait_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_last_q  <= cmd_last_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;
  assign cmd_last  = cmd_last_q;
  assign init_done = (state_q == StDone);
  assign init_err  = (state_q == StErr);
  assign busy      = !(state_q inside {StDone, StErr});

endmodule

// File: tb/tb_spi_flash_init_seq.sv
// Directed bench for spi_flash_init_seq. Three instances cover the parameter corners;
// the one selected by sel sees the shared stimulus, the others are held in reset.
module tb_spi_flash_init_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sel;
  logic       cmd_ready;
  logic       rx_valid;
  logic [7:0] rx_byte;

  logic [2:0] rst_v, cv_v, cl_v, dn_v, er_v, bz_v;
  logic [7:0] cb_v [3];

  logic       cv, cl, dn, er, bz;
  logic [7:0] cb;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rst_v[0] = rst_n && (sel == 2'd0);
  assign rst_v[1] = rst_n && (sel == 2'd1);
  assign rst_v[2] = rst_n && (sel == 2'd2);

  // A: nominal parameters with a short wait.
  spi_flash_init_seq #(.RST_WAIT_CYCLES(8), .ENABLE_QE(1'b1), .MAX_POLLS(255)) u_a (
    .clk(clk), .rst_n(rst_v[0]), .cmd_valid(cv_v[0]), .cmd_ready(cmd_ready),
    .cmd_byte(cb_v[0]), .cmd_last(cl_v[0]), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .init_done(dn_v[0]), .init_err(er_v[0]), .busy(bz_v[0])
  );

  // B: poll timeout corner.
  spi_flash_init_seq #(.RST_WAIT_CYCLES(2), .ENABLE_QE(1'b1), .MAX_POLLS(3)) u_b (
    .clk(clk), .rst_n(rst_v[1]), .cmd_valid(cv_v[1]), .cmd_ready(cmd_ready),
    .cmd_byte(cb_v[1]), .cmd_last(cl_v[1]), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .init_done(dn_v[1]), .init_err(er_v[1]), .busy(bz_v[1])
  );

  // C: no quad-enable, reset-only sequence.
  spi_flash_init_seq #(.RST_WAIT_CYCLES(5), .ENABLE_QE(1'b0), .MAX_POLLS(255)) u_c (
    .clk(clk), .rst_n(rst_v[2]), .cmd_valid(cv_v[2]), .cmd_ready(cmd_ready),
    .cmd_byte(cb_v[2]), .cmd_last(cl_v[2]), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .init_done(dn_v[2]), .init_err(er_v[2]), .busy(bz_v[2])
  );

  always_comb begin
    case (sel)
      2'd1:    begin cv = cv_v[1]; cb = cb_v[1]; cl = cl_v[1]; dn = dn_v[1]; er = er_v[1]; bz = bz_v[1]; end
      2'd2:    begin cv = cv_v[2]; cb = cb_v[2]; cl = cl_v[2]; dn = dn_v[2]; er = er_v[2]; bz = bz_v[2]; end
      default: begin cv = cv_v[0]; cb = cb_v[0]; cl = cl_v[0]; dn = dn_v[0]; er = er_v[0]; bz = bz_v[0]; end
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte-engine model: wait for the request, optionally stall, accept, reply 3 cycles later.
  task automatic serve(input string tag, input logic [7:0] b, input logic l,
                       input logic [7:0] resp, input int delay);
    int t = 0;
    while (cv !== 1'b1 && t < 100) begin
      step();
      t++;
    end
    check({tag, " valid"}, 32'(cv), 32'd1);
    check({tag, " byte"}, 32'(cb), 32'(b));
    check({tag, " last"}, 32'(cl), 32'(l));
    for (int i = 0; i < delay; i++) begin
      step();
      check({tag, " hold valid"}, 32'(cv), 32'd1);
      check({tag, " hold byte"}, 32'(cb), 32'(b));
      check({tag, " hold last"}, 32'(cl), 32'(l));
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check({tag, " drop"}, 32'(cv), 32'd0);
    step();
    step();
    check({tag, " wait rx"}, 32'(cv), 32'd0);
    rx_valid = 1'b1;
    rx_byte  = resp;
    step();
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    sel = 2'd0; rst_n = 1'b0; cmd_ready = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (3) step();

    // Reset values.
    check("rst cmd_valid", 32'(cv), 32'd0);
    check("rst cmd_byte", 32'(cb), 32'h00);
    check("rst cmd_last", 32'(cl), 32'd0);
    check("rst init_done", 32'(dn), 32'd0);
    check("rst init_err", 32'(er), 32'd0);
    check("rst busy", 32'(bz), 32'd1);

    // Nominal run, ready never stalls.
    rst_n = 1'b1;
    step();
    check("autostart valid", 32'(cv), 32'd1);
    check("autostart byte", 32'(cb), 32'h66);
    serve("n rsten", 8'h66, 1'b1, 8'h00, 0);
    serve("n rst", 8'h99, 1'b1, 8'h00, 0);
    for (int k = 0; k < 8; k++) begin
      check("n rwait idle", 32'(cv), 32'd0);
      check("n rwait busy", 32'(bz), 32'd1);
      step();
    end
    check("n rwait end valid", 32'(cv), 32'd1);
    check("n rwait end byte", 32'(cb), 32'h06);
    serve("n wren", 8'h06, 1'b1, 8'h00, 0);
    serve("n wrsr0", 8'h01, 1'b0, 8'h00, 0);
    serve("n wrsr1", 8'h40, 1'b1, 8'h00, 0);
    serve("n rdsr cmd", 8'h05, 1'b0, 8'h00, 0);
    serve("n rdsr rd", 8'h00, 1'b1, 8'h00, 0);
    check("n done", 32'(dn), 32'd1);
    check("n busy low", 32'(bz), 32'd0);
    check("n err low", 32'(er), 32'd0);
    check("n done quiet", 32'(cv), 32'd0);
    rx_valid = 1'b1; rx_byte = 8'h01;
    step();
    rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (3) step();
    check("n done sticky", 32'(dn), 32'd1);
    check("n done still quiet", 32'(cv), 32'd0);

    // Backpressure on 0x01 and two busy polls.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    serve("b rsten", 8'h66, 1'b1, 8'h00, 0);
    serve("b rst", 8'h99, 1'b1, 8'h00, 0);
    serve("b wren", 8'h06, 1'b1, 8'h00, 0);
    serve("b wrsr0", 8'h01, 1'b0, 8'h00, 5);
    serve("b wrsr1", 8'h40, 1'b1, 8'h00, 0);
    serve("b poll1 cmd", 8'h05, 1'b0, 8'h00, 0);
    serve("b poll1 rd", 8'h00, 1'b1, 8'h01, 0);
    check("b poll1 not done", 32'(dn), 32'd0);
    serve("b poll2 cmd", 8'h05, 1'b0, 8'h00, 0);
    serve("b poll2 rd", 8'h00, 1'b1, 8'h01, 0);
    check("b poll2 not done", 32'(dn), 32'd0);
    serve("b poll3 cmd", 8'h05, 1'b0, 8'h00, 0);
    serve("b poll3 rd", 8'h00, 1'b1, 8'hFE, 0);
    check("b done", 32'(dn), 32'd1);
    check("b done quiet", 32'(cv), 32'd0);

    // Spurious rx_valid during ISSUE, then reset during RWAIT and during a byte.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    step();
    check("s spurious valid", 32'(cv), 32'd1);
    check("s spurious byte", 32'(cb), 32'h66);
    serve("s rsten", 8'h66, 1'b1, 8'h00, 0);
    serve("s rst", 8'h99, 1'b1, 8'h00, 0);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("s rwait rst valid", 32'(cv), 32'd0);
    check("s rwait rst busy", 32'(bz), 32'd1);
    check("s rwait rst done", 32'(dn), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("s restart valid", 32'(cv), 32'd1);
    check("s restart byte", 32'(cb), 32'h66);
    check("s restart last", 32'(cl), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s async valid", 32'(cv), 32'd0);
    check("s async byte", 32'(cb), 32'h00);
    check("s async last", 32'(cl), 32'd0);
    step();

    // Poll timeout with MAX_POLLS=3.
    sel = 2'd1;
    step();
    rst_n = 1'b1;
    serve("t rsten", 8'h66, 1'b1, 8'h00, 0);
    serve("t rst", 8'h99, 1'b1, 8'h00, 0);
    serve("t wren", 8'h06, 1'b1, 8'h00, 0);
    serve("t wrsr0", 8'h01, 1'b0, 8'h00, 0);
    serve("t wrsr1", 8'h40, 1'b1, 8'h00, 0);
    for (int p = 0; p < 3; p++) begin
      serve("t poll cmd", 8'h05, 1'b0, 8'h00, 0);
      serve("t poll rd", 8'h00, 1'b1, 8'h03, 0);
      check("t err level", 32'(er), (p == 2) ? 32'd1 : 32'd0);
    end
    check("t done low", 32'(dn), 32'd0);
    check("t busy low", 32'(bz), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (cv) seen = 1'b1;
      step();
    end
    check("t err quiet", 32'(seen), 32'd0);
    check("t err sticky", 32'(er), 32'd1);

    // ENABLE_QE=0: reset commands only, done RST_WAIT_CYCLES after the 0x99 reply.
    rst_n = 1'b0;
    sel = 2'd2;
    step();
    rst_n = 1'b1;
    serve("q rsten", 8'h66, 1'b1, 8'h00, 0);
    serve("q rst", 8'h99, 1'b1, 8'h00, 0);
    for (int k = 0; k < 5; k++) begin
      check("q wait not done", 32'(dn), 32'd0);
      check("q wait quiet", 32'(cv), 32'd0);
      step();
    end
    check("q done", 32'(dn), 32'd1);
    check("q busy low", 32'(bz), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (cv) seen = 1'b1;
      step();
    end
    check("q done quiet", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_init_seq.md
SPI_FLASH_INIT_SEQ -- requirements
Module: spi_flash_init_seq

Interface
REQ-001 SHALL have parameter RST_WAIT_CYCLES, default 1000: cycles idled after the 0x99 software-reset command.
REQ-002 SHALL have parameter ENABLE_QE, default 1: when 1, perform the quad-enable status write and poll.
REQ-003 SHALL have parameter MAX_POLLS, default 255: maximum status reads before error.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port cmd_valid  output  1  byte request to the SPI byte engine.
REQ-007 SHALL have port cmd_ready  input  1  byte engine accepts cmd_byte.
REQ-008 SHALL have port cmd_byte  output  8  byte to shift out.
REQ-009 SHALL have port cmd_last  output  1  deassert CS after this byte.
REQ-010 SHALL have port rx_valid  input  1  one-cycle pulse: the last accepted byte finished shifting.
REQ-011 SHALL have port rx_byte  input  8  MISO byte captured during that transfer; valid with rx_valid.
REQ-012 SHALL have port init_done  output  1  level: flash configured; feeds the cache FSM init_done.
REQ-013 SHALL have port init_err  output  1  level: status poll timed out.
REQ-014 SHALL have port busy  output  1  sequence in progress.

Function
REQ-015 SHALL start the sequence automatically in the first cycle after rst_n deasserts; there is no start input.
REQ-016 SHALL issue bytes in this order, each group followed by CS release (cmd_last=1 on the final byte): RSTEN {0x66}; RST {0x99}; wait RST_WAIT_CYCLES; if ENABLE_QE: WREN {0x06}; WRSR {0x01, 0x40}; then poll RDSR {0x05, 0x00} until the WIP bit is clear.
REQ-017 SHALL use these states: RSTEN, RST, RWAIT, WREN, WRSR0, WRSR1, POLL_CMD, POLL_RD, DONE, ERR. Each byte state SHALL have an ISSUE phase and a WAIT_RX phase.
REQ-018 ISSUE phase SHALL hold cmd_valid=1 with cmd_byte and cmd_last stable until the cycle in which cmd_valid&&cmd_ready; cmd_valid SHALL drop in the following cycle.
REQ-019 WAIT_RX phase SHALL hold cmd_valid=0 until rx_valid; the next byte's cmd_valid SHALL assert in the cycle after the rx_valid pulse, never earlier.
REQ-020 SHALL ignore an rx_valid pulse arriving while in an ISSUE phase or in RWAIT/DONE/ERR.
REQ-021 RWAIT SHALL last exactly RST_WAIT_CYCLES cycles, counted from the cycle after the RST rx_valid; RST_WAIT_CYCLES=0 SHALL proceed immediately.
REQ-022 With ENABLE_QE=0, RWAIT SHALL transition directly to DONE.
REQ-023 In POLL_RD, on rx_valid with rx_byte[0]=0 SHALL go to DONE; with rx_byte[0]=1 SHALL increment the poll counter and return to POLL_CMD.
REQ-024 SHALL go to ERR when rx_byte[0]=1 on poll number MAX_POLLS; the counter SHALL be wide enough that MAX_POLLS does not wrap.
REQ-025 SHALL hold init_done=1 only in DONE, init_err=1 only in ERR, and busy=1 in every other state; DONE and ERR SHALL be terminal until reset.
REQ-026 SHALL issue no cmd_valid in DONE or ERR.
REQ-027 SHALL ignore rx_byte contents except rx_byte[0] in POLL_RD.

Reset
REQ-028 SHALL, while rst_n=0, force: state RSTEN-ISSUE, cmd_valid=0, cmd_byte=0x00, cmd_last=0, init_done=0, init_err=0, busy=1, counters=0.
REQ-029 Reset asserted mid-byte or mid-wait SHALL abort immediately and restart from RSTEN after release; the byte engine owns CS recovery.

Verification
REQ-030 Nominal, ENABLE_QE=1, RST_WAIT_CYCLES=8, cmd_ready always 1, rx_valid 3 cycles after accept, first poll rx_byte=0x00 -> bytes 66L,99L,06L,01,40L,05,00L in order; init_done rises; busy falls.
REQ-031 Backpressure: cmd_ready low for 5 cycles on byte 0x01 -> cmd_valid, cmd_byte=0x01, cmd_last=0 stable throughout; single acceptance.
REQ-032 Poll retry: rx_byte=0x01 twice, then 0x00 -> exactly three 05/00 pairs, then DONE.
REQ-033 Timeout: MAX_POLLS=3, rx_byte always 0x03 -> three poll pairs, init_err=1, init_done=0, no further cmd_valid.
REQ-034 ENABLE_QE=0 -> only 66L, 99L; init_done asserts exactly RST_WAIT_CYCLES cycles after the 99 rx_valid.
REQ-035 Reset during RWAIT and a spurious rx_valid during ISSUE -> outputs at reset values asynchronously; restart with 0x66; spurious pulse does not advance state.
